// File: rtl/bkram_pkg.sv
// Shared types and constants for the backup-RAM save/load sequencer.
package bkram_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT_ACK,
      WAIT_END
   } state_t;

   typedef enum logic {
      OP_LOAD,
      OP_SAVE
   } op_t;

   localparam int unsigned SECTOR_BYTES = 512;

endpackage

// File: rtl/bkram_edge.sv
// Rise/fall detector against a registered copy of the input. The first cycle
// after reset only primes the copy, so a level already high is not an edge.
module bkram_edge (
   input  logic clk_sys,
   input  logic reset,
   input  logic i_d,
   output logic o_rise,
   output logic o_fall
);

   logic r_prev;
   logic r_valid;

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         r_prev  <= 1'b0;
         r_valid <= 1'b0;
      end else begin
         r_prev  <= i_d;
         r_valid <= 1'b1;
      end
   end

   assign o_rise = r_valid &  i_d & ~r_prev;
   assign o_fall = r_valid & ~i_d &  r_prev;

endmodule

// File: rtl/bkram_seq.sv
// Save-slot backup-RAM sequencer: streams one slot of 512-byte sectors to or
// from the host. Optional idle-dirty autosave is enabled by BKRAM_AUTOSAVE_EN.
module bkram_seq
   import bkram_pkg::*;
#(
   parameter int unsigned SLOT_BITS       = 2,
   parameter int unsigned SECTOR_BITS     = 7,
   parameter logic [23:0] AUTOSAVE_CYCLES = 24'd10_000_000
) (
   input  logic                 clk_sys,
   input  logic                 reset,
   input  logic                 bk_ena,
   input  logic [SLOT_BITS-1:0] slot,
   input  logic                 load_req,
   input  logic                 save_req,
   input  logic                 bram_wr,
   input  logic                 sd_ack,
   output logic [31:0]          sd_lba,
   output logic                 sd_rd,
   output logic                 sd_wr,
   output logic                 bk_loading,
   output logic                 bk_busy,
   output logic                 bk_dirty,
   output logic                 bk_done
);

   state_t                 r_state;
   op_t                    r_op;
   logic [SLOT_BITS-1:0]   r_slot;
   logic [SECTOR_BITS-1:0] r_sector;
   logic [31:0]            r_lba;
   logic                   r_rd;
   logic                   r_wr;
   logic                   r_loading;
   logic                   r_dirty;
   logic                   r_done;

   logic                   w_load_rise;
   logic                   w_save_rise;
   logic                   w_ack_rise;
   logic                   w_ack_fall;
   logic                   w_as_fire;
   logic                   w_start_load;
   logic                   w_start_save;
   logic                   w_last;
   logic                   w_load_done;
   logic [SECTOR_BITS-1:0] w_sector_inc;
   logic [31:0]            w_lba_start;
   logic [31:0]            w_lba_next;

   bkram_edge u_edge_load (
      .clk_sys (clk_sys),
      .reset   (reset),
      .i_d     (load_req),
      .o_rise  (w_load_rise),
      .o_fall  ()
   );

   bkram_edge u_edge_save (
      .clk_sys (clk_sys),
      .reset   (reset),
      .i_d     (save_req),
      .o_rise  (w_save_rise),
      .o_fall  ()
   );

   bkram_edge u_edge_ack (
      .clk_sys (clk_sys),
      .reset   (reset),
      .i_d     (sd_ack),
      .o_rise  (w_ack_rise),
      .o_fall  (w_ack_fall)
   );

   // Load wins over a simultaneous save edge or autosave; losers are dropped.
   assign w_start_load = (r_state == IDLE) & bk_ena & w_load_rise;
   assign w_start_save = (r_state == IDLE) & bk_ena & ~w_load_rise & (w_save_rise | w_as_fire);

   assign w_last       = &r_sector;
   assign w_load_done  = (r_state == WAIT_END) & w_ack_fall & w_last & (r_op == OP_LOAD);
   assign w_sector_inc = r_sector + 1'b1;
   assign w_lba_start  = 32'({slot, {SECTOR_BITS{1'b0}}});
   assign w_lba_next   = 32'({r_slot, w_sector_inc});

`ifdef BKRAM_AUTOSAVE_EN
   logic [23:0] r_as_cnt;
   logic        w_as_count;

   assign w_as_count = r_dirty & bk_ena & (r_state == IDLE) & ~bram_wr;
   assign w_as_fire  = w_as_count & (r_as_cnt == AUTOSAVE_CYCLES - 24'd1);

   always_ff @(posedge clk_sys) begin
      if (reset || bram_wr || w_start_load || w_start_save) begin
         r_as_cnt <= 24'd0;
      end else if (w_as_count) begin
         r_as_cnt <= r_as_cnt + 24'd1;
      end
   end
`else
   assign w_as_fire = 1'b0;
`endif

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         r_state   <= IDLE;
         r_op      <= OP_LOAD;
         r_slot    <= '0;
         r_sector  <= '0;
         r_lba     <= 32'd0;
         r_rd      <= 1'b0;
         r_wr      <= 1'b0;
         r_loading <= 1'b0;
         r_dirty   <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         // bk_loading stays up through the bk_done cycle itself
         if (r_done) begin
            r_loading <= 1'b0;
         end

         if (w_start_save || w_load_done) begin
            r_dirty <= bram_wr;
         end else if (bram_wr && !r_loading) begin
            r_dirty <= 1'b1;
         end

         case (r_state)
            IDLE: begin
               if (w_start_load || w_start_save) begin
                  r_slot    <= slot;
                  r_op      <= w_start_load ? OP_LOAD : OP_SAVE;
                  r_sector  <= '0;
                  r_lba     <= w_lba_start;
                  r_loading <= w_start_load;
                  r_state   <= ISSUE;
               end
            end
            ISSUE: begin
               r_rd    <= (r_op == OP_LOAD);
               r_wr    <= (r_op == OP_SAVE);
               r_state <= WAIT_ACK;
            end
            WAIT_ACK: begin
               if (w_ack_rise) begin
                  r_rd    <= 1'b0;
                  r_wr    <= 1'b0;
                  r_state <= WAIT_END;
               end
            end
            WAIT_END: begin
               if (w_ack_fall) begin
                  if (w_last) begin
                     r_done  <= 1'b1;
                     r_state <= IDLE;
                  end else begin
                     r_sector <= w_sector_inc;
                     r_lba    <= w_lba_next;
                     r_state  <= ISSUE;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign sd_lba     = r_lba;
   assign sd_rd      = r_rd;
   assign sd_wr      = r_wr;
   assign bk_loading = r_loading;
   assign bk_busy    = (r_state != IDLE);
   assign bk_dirty   = r_dirty;
   assign bk_done    = r_done;

endmodule

// File: tb/tb_bkram_seq.sv
// Self-checking bench for bkram_seq: a host model answers sector requests and
// checks each one against a queue of expected {lba, direction} entries.
module tb_bkram_seq;

   logic        clk_sys  = 1'b0;
   logic        reset    = 1'b1;
   logic        bk_ena   = 1'b0;
   logic [1:0]  slot     = 2'd0;
   logic        load_req = 1'b0;
   logic        save_req = 1'b0;
   logic        bram_wr  = 1'b0;
   logic        sd_ack   = 1'b0;
   logic [31:0] sd_lba;
   logic        sd_rd;
   logic        sd_wr;
   logic        bk_loading;
   logic        bk_busy;
   logic        bk_dirty;
   logic        bk_done;

   bkram_seq #(
      .SLOT_BITS       (2),
      .SECTOR_BITS     (7),
      .AUTOSAVE_CYCLES (24'd100)
   ) dut (
      .clk_sys    (clk_sys),
      .reset      (reset),
      .bk_ena     (bk_ena),
      .slot       (slot),
      .load_req   (load_req),
      .save_req   (save_req),
      .bram_wr    (bram_wr),
      .sd_ack     (sd_ack),
      .sd_lba     (sd_lba),
      .sd_rd      (sd_rd),
      .sd_wr      (sd_wr),
      .bk_loading (bk_loading),
      .bk_busy    (bk_busy),
      .bk_dirty   (bk_dirty),
      .bk_done    (bk_done)
   );

   always #5 clk_sys = ~clk_sys;

   typedef struct {
      logic [31:0] lba;
      logic        is_rd;
   } exp_t;

   typedef struct {
      logic       ld;
      logic       sv;
      logic       ena;
      logic [1:0] slot;
      logic       exp_busy;
      logic       exp_rd;
      int         exp_sectors;
   } vec_t;

   exp_t sb_q[$];
   int   errors     = 0;
   int   checks     = 0;
   int   rd_count   = 0;
   int   wr_count   = 0;
   int   done_count = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   task automatic push_xfer(input logic [1:0] s, input logic ld);
      for (int i = 0; i < 128; i++) begin
         sb_q.push_back('{lba: 32'({s, 7'(i)}), is_rd: ld});
      end
   endtask

   task automatic wait_done(output bit ok);
      ok = 1'b0;
      for (int k = 0; k < 3000 && !ok; k++) begin
         @(negedge clk_sys);
         if (bk_done) ok = 1'b1;
      end
   endtask

   task automatic pulse_req(input logic ld, input logic sv);
      load_req = ld;
      save_req = sv;
      @(negedge clk_sys);
      load_req = 1'b0;
      save_req = 1'b0;
   endtask

   // Host model: ack each request, drop ack only after the request clears.
   initial begin : host
      exp_t e;
      bit   cleared;
      forever begin
         @(negedge clk_sys);
         if (sd_rd || sd_wr) begin
            if (sd_rd) rd_count++;
            if (sd_wr) wr_count++;
            if (sb_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_req: got lba 0x%0h rd=%0b wr=%0b, expected none",
                        sd_lba, sd_rd, sd_wr);
            end else begin
               e = sb_q.pop_front();
               check("sd_lba", sd_lba, e.lba);
               check("sd_rd", 32'(sd_rd), 32'(e.is_rd));
               check("sd_wr", 32'(sd_wr), 32'(!e.is_rd));
            end
            @(negedge clk_sys);
            sd_ack = 1'b1;
            cleared = 1'b0;
            for (int k = 0; k < 20 && !cleared; k++) begin
               @(negedge clk_sys);
               cleared = !(sd_rd || sd_wr);
            end
            if (!cleared) check("req_clear", 32'd0, 32'd1);
            @(negedge clk_sys);
            sd_ack = 1'b0;
         end
      end
   end

   always @(negedge clk_sys) if (bk_done) done_count++;

   initial begin : watchdog
      #5_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1, "watchdog");
   end

   initial begin : main
      vec_t vecs[5];
      bit   ok;
      bit   found;
      int   wr0, rd0, d0, n;

      vecs[0] = '{ld: 1'b0, sv: 1'b1, ena: 1'b1, slot: 2'd2, exp_busy: 1'b1, exp_rd: 1'b0,
                  exp_sectors: 128};
      vecs[1] = '{ld: 1'b1, sv: 1'b0, ena: 1'b1, slot: 2'd3, exp_busy: 1'b1, exp_rd: 1'b1,
                  exp_sectors: 128};
      vecs[2] = '{ld: 1'b1, sv: 1'b1, ena: 1'b1, slot: 2'd1, exp_busy: 1'b1, exp_rd: 1'b1,
                  exp_sectors: 128};
      vecs[3] = '{ld: 1'b0, sv: 1'b1, ena: 1'b0, slot: 2'd2, exp_busy: 1'b0, exp_rd: 1'b0,
                  exp_sectors: 0};
      vecs[4] = '{ld: 1'b0, sv: 1'b1, ena: 1'b1, slot: 2'd0, exp_busy: 1'b1, exp_rd: 1'b0,
                  exp_sectors: 128};

      // Reset with save_req held high: the level must not count as an edge.
      save_req = 1'b1;
      bk_ena   = 1'b1;
      repeat (3) @(negedge clk_sys);
      check("rst_lba", sd_lba, 32'd0);
      check("rst_rd_wr", {30'd0, sd_rd, sd_wr}, 32'd0);
      check("rst_flags", {28'd0, bk_loading, bk_busy, bk_dirty, bk_done}, 32'd0);
      reset = 1'b0;
      repeat (5) @(negedge clk_sys);
      check("held_level_no_edge", 32'(bk_busy), 32'd0);
      save_req = 1'b0;
      @(negedge clk_sys);

      for (int v = 0; v < 5; v++) begin
         wr0 = wr_count;
         rd0 = rd_count;
         d0  = done_count;
         slot   = vecs[v].slot;
         bk_ena = vecs[v].ena;
         bram_wr = 1'b1;
         @(negedge clk_sys);
         bram_wr = 1'b0;
         @(negedge clk_sys);
         check("dirty_pre", 32'(bk_dirty), 32'd1);
         if (vecs[v].exp_busy) push_xfer(vecs[v].slot, vecs[v].exp_rd);
         pulse_req(vecs[v].ld, vecs[v].sv);
         check("busy_accept", 32'(bk_busy), 32'(vecs[v].exp_busy));
         check("loading_accept", 32'(bk_loading), 32'(vecs[v].exp_busy & vecs[v].exp_rd));
         if (vecs[v].exp_busy) begin
            wait_done(ok);
            check("done_seen", 32'(ok), 32'd1);
            check("loading_at_done", 32'(bk_loading), 32'(vecs[v].exp_rd));
            @(negedge clk_sys);
            check("loading_after", 32'(bk_loading), 32'd0);
            check("dirty_after", 32'(bk_dirty), 32'd0);
         end
         repeat (20) @(negedge clk_sys);
         check("idle_after", 32'(bk_busy), 32'd0);
         check("sectors", 32'((wr_count - wr0) + (rd_count - rd0)), 32'(vecs[v].exp_sectors));
         check("rd_pulses", 32'(rd_count - rd0), vecs[v].exp_rd ? 32'd128 : 32'd0);
         check("done_count", 32'(done_count - d0), 32'(vecs[v].exp_busy));
         check("sb_drained", 32'(sb_q.size()), 32'd0);
      end

      // Requests during a transfer are ignored; bk_ena falling does not abort.
      bk_ena = 1'b1;
      slot   = 2'd2;
      wr0 = wr_count;
      rd0 = rd_count;
      d0  = done_count;
      push_xfer(2'd2, 1'b0);
      pulse_req(1'b0, 1'b1);
      found = 1'b0;
      for (int k = 0; k < 500 && !found; k++) begin
         @(negedge clk_sys);
         found = (wr_count - wr0) >= 10;
      end
      check("busy_midway", 32'(found & bk_busy), 32'd1);
      slot = 2'd0;
      load_req = 1'b1;
      save_req = 1'b1;
      repeat (2) @(negedge clk_sys);
      load_req = 1'b0;
      save_req = 1'b0;
      bk_ena   = 1'b0;
      wait_done(ok);
      check("busy_req_done", 32'(ok), 32'd1);
      repeat (20) @(negedge clk_sys);
      check("busy_req_sectors", 32'(wr_count - wr0), 32'd128);
      check("busy_req_no_rd", 32'(rd_count - rd0), 32'd0);
      check("busy_req_done_cnt", 32'(done_count - d0), 32'd1);
      check("busy_req_sb", 32'(sb_q.size()), 32'd0);

      // Reset at sector 0x45 of a slot-1 save, then a fresh save from sector 0.
      bk_ena = 1'b1;
      slot   = 2'd1;
      d0     = done_count;
      push_xfer(2'd1, 1'b0);
      bram_wr = 1'b1;
      @(negedge clk_sys);
      bram_wr = 1'b0;
      pulse_req(1'b0, 1'b1);
      found = 1'b0;
      for (int k = 0; k < 3000 && !found; k++) begin
         @(negedge clk_sys);
         found = sd_wr && (sd_lba == 32'h0C5);
      end
      check("reach_sector_45", 32'(found), 32'd1);
      bram_wr = 1'b1;
      reset   = 1'b1;
      @(negedge clk_sys);
      bram_wr = 1'b0;
      check("abort_lba", sd_lba, 32'd0);
      check("abort_rd_wr", {30'd0, sd_rd, sd_wr}, 32'd0);
      check("abort_flags", {28'd0, bk_loading, bk_busy, bk_dirty, bk_done}, 32'd0);
      reset = 1'b0;
      repeat (10) @(negedge clk_sys);
      sb_q.delete();
      check("abort_no_done", 32'(done_count - d0), 32'd0);
      check("abort_idle", 32'(bk_busy), 32'd0);
      wr0 = wr_count;
      push_xfer(2'd1, 1'b0);
      pulse_req(1'b0, 1'b1);
      wait_done(ok);
      check("restart_done", 32'(ok), 32'd1);
      repeat (10) @(negedge clk_sys);
      check("restart_sectors", 32'(wr_count - wr0), 32'd128);
      check("restart_sb", 32'(sb_q.size()), 32'd0);

`ifdef BKRAM_AUTOSAVE_EN
      // Autosave after 100 idle-dirty cycles, and a second bram_wr restarts the count.
      slot = 2'd3;
      for (int pass = 0; pass < 2; pass++) begin
         push_xfer(2'd3, 1'b0);
         bram_wr = 1'b1;
         @(negedge clk_sys);
         bram_wr = 1'b0;
         if (pass == 1) begin
            repeat (49) @(negedge clk_sys);
            check("as_quiet_before_rewr", 32'(bk_busy), 32'd0);
            bram_wr = 1'b1;
            @(negedge clk_sys);
            bram_wr = 1'b0;
         end
         n = 0;
         for (int k = 1; k <= 150 && n == 0; k++) begin
            @(negedge clk_sys);
            if (bk_busy) n = k;
         end
         check("as_delay", 32'(n), 32'd100);
         wait_done(ok);
         check("as_done", 32'(ok), 32'd1);
         repeat (10) @(negedge clk_sys);
         check("as_dirty", 32'(bk_dirty), 32'd0);
         check("as_sb", 32'(sb_q.size()), 32'd0);
      end
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
